tdr_line_sim_multi: RTL and testbench

Parametrised multi-fault transmission-line model for the TDR fault-detector FPGA design. Accepts a stream of signed incident-pulse samples, delays them through a round-trip history buffer, and sums the incident sample with one scaled, sign-corrected echo per configured fault. It generates synthetic waveforms for the capture/feature-extraction path and the ML dataset generator. Fault configuration is double-buffered and only takes effect while the line is quiet.

---
 rtl/tdr_line_sim_multi.sv | 193 +++++++++++++++++++
 tb/tb_tdr_line_sim_multi.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tdr_line_sim_multi.sv
// tdr_line_sim_multi
//   Multi-fault transmission-line model. Incident samples are pushed through a
//   2*LINE_LEN round-trip history. Each output is the incident sample plus
//   one echo per fault slot. An echo is the history tap at 2*d, shifted right
//   arithmetically and sign-corrected by fault type. The result is saturated
//   to DATA_W.
//   Fault configuration is double-buffered: cfg_load captures into a pending
//   register, and that register is copied to the active one only once the
//   line is quiet, so an echo never mixes two configurations.
//
//   Optional feature: define TDR_NOISE_EN to add 2-bit LFSR noise (-2..+1)
//   before saturation. With the macro undefined the output is deterministic.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_sample   incident sample (zero injected when in_valid low)
//   fault_type            per slot: 00 none, 01 open, 10 short, 11 partial
//   fault_delay           per slot one-way distance, 1..LINE_LEN, 0 = off
//   fault_shift           per slot attenuation (arithmetic >> 0..7)
//   cfg_load              capture fault_* into the pending register
//   out_valid, out_sample saturated line waveform, 1-cycle latency
//   line_quiet            no nonzero sample left in the history
//   cfg_pending           captured configuration not yet applied
module tdr_line_sim_multi #(
  parameter int DATA_W     = 12,
  parameter int LINE_LEN   = 64,
  parameter int NUM_FAULTS = 2,
  parameter int DLY_W      = $clog2(LINE_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_sample,
  input  logic [2*NUM_FAULTS-1:0]     fault_type,
  input  logic [DLY_W*NUM_FAULTS-1:0] fault_delay,
  input  logic [3*NUM_FAULTS-1:0]     fault_shift,
  input  logic                        cfg_load,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_sample,
  output logic                        line_quiet,
  output logic                        cfg_pending
);

  localparam int HIST  = 2 * LINE_LEN;
  localparam int SUM_W = DATA_W + $clog2(NUM_FAULTS + 1) + 1;
  localparam int CNT_W = $clog2(HIST + 1);
  localparam int MAXV  = 2**(DATA_W-1) - 1;
  localparam int MINV  = -(2**(DATA_W-1));

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} cfg_state_t;

  cfg_state_t state;

  // hist[i] holds the sample injected i+1 cycles ago.
  logic signed [DATA_W-1:0] hist [HIST];
  logic [CNT_W-1:0]         quiet_cnt;

  logic [2*NUM_FAULTS-1:0]     pend_type,  act_type;
  logic [DLY_W*NUM_FAULTS-1:0] pend_delay, act_delay;
  logic [3*NUM_FAULTS-1:0]     pend_shift, act_shift;

  logic signed [DATA_W-1:0] s;
  logic signed [SUM_W-1:0]  line_sum;
  logic signed [SUM_W-1:0]  tap_ext;
  logic signed [SUM_W-1:0]  echo;
  logic signed [DATA_W-1:0] tap;
  logic [1:0]               typ;
  logic [DLY_W-1:0]         dly;
  logic [3:0]               sh;
  logic [DATA_W-1:0]        sat_out;

`ifdef TDR_NOISE_EN
  logic [15:0] lfsr;
`endif

  assign line_quiet = (quiet_cnt == '0);

  always_comb begin
    s        = in_valid ? $signed(in_sample) : '0;
    line_sum = {{(SUM_W-DATA_W){s[DATA_W-1]}}, s};
    typ      = '0;
    dly      = '0;
    sh       = '0;
    tap      = '0;
    tap_ext  = '0;
    echo     = '0;
    for (int k = 0; k < NUM_FAULTS; k++) begin
      typ = act_type[2*k +: 2];
      dly = act_delay[DLY_W*k +: DLY_W];
      // Partial faults reflect half as much as an open at the same shift.
      sh  = {1'b0, act_shift[3*k +: 3]} + {3'b0, (typ == 2'b11)};
      // Out-of-range or zero delay matches no tap, so the echo is zero.
      tap = '0;
      for (int j = 1; j <= LINE_LEN; j++)
        if (dly == DLY_W'(j)) tap = hist[2*j-1];
      tap_ext = {{(SUM_W-DATA_W){tap[DATA_W-1]}}, tap};
      echo    = tap_ext >>> sh;
      case (typ)
        2'b01, 2'b11: line_sum = line_sum + echo;
        2'b10:        line_sum = line_sum - echo;
        default:      ;
      endcase
    end
`ifdef TDR_NOISE_EN
    line_sum = line_sum + {{(SUM_W-2){lfsr[1]}}, lfsr[1:0]};
`endif
    if (line_sum > SUM_W'(MAXV))
      sat_out = DATA_W'(MAXV);
    else if (line_sum < SUM_W'(MINV))
      sat_out = DATA_W'(MINV);
    else
      sat_out = line_sum[DATA_W-1:0];
  end

  // Datapath: history, quiet counter, output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST; i++) hist[i] <= '0;
      quiet_cnt  <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      hist[0] <= s;
      for (int i = 1; i < HIST; i++) hist[i] <= hist[i-1];
      if (s != '0)
        quiet_cnt <= CNT_W'(HIST);
      else if (quiet_cnt != '0)
        quiet_cnt <= quiet_cnt - 1'b1;
      out_valid  <= 1'b1;
      out_sample <= sat_out;
    end
  end

  // Configuration FSM. The copy to the active register happens in APPLY,
  // which is only entered after the line was observed quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg_pending <= 1'b0;
      pend_type   <= '0;
      pend_delay  <= '0;
      pend_shift  <= '0;
      act_type    <= '0;
      act_delay   <= '0;
      act_shift   <= '0;
    end else begin
      if (cfg_load) begin
        pend_type  <= fault_type;
        pend_delay <= fault_delay;
        pend_shift <= fault_shift;
      end
      case (state)
        IDLE: begin
          if (cfg_load) begin
            state       <= PENDING;
            cfg_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (line_quiet) state <= APPLY;
          cfg_pending <= 1'b1;
        end
        APPLY: begin
          act_type  <= pend_type;
          act_delay <= pend_delay;
          act_shift <= pend_shift;
          if (cfg_load) begin
            state       <= PENDING;
            cfg_pending <= 1'b1;
          end else begin
            state       <= IDLE;
            cfg_pending <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          cfg_pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef TDR_NOISE_EN
  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (!rst_n)
      lfsr <= 16'hACE1;
    else
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

endmodule

// File: tb/tb_tdr_line_sim_multi.sv
module tb_tdr_line_sim_multi;

  localparam int DATA_W = 12;
  localparam int LINE_LEN = 64;
  localparam int NF = 2;
  localparam int DLY_W = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [DATA_W-1:0] in_sample;
  logic [2*NF-1:0] fault_type;
  logic [DLY_W*NF-1:0] fault_delay;
  logic [3*NF-1:0] fault_shift;
  logic cfg_load;
  logic out_valid;
  logic [DATA_W-1:0] out_sample;
  logic line_quiet;
  logic cfg_pending;

  int checks = 0;
  int errors = 0;
  int sb[$];
  string phase = "reset";

  always #5 clk = ~clk;

  tdr_line_sim_multi #(.DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .NUM_FAULTS(NF)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample),
    .fault_type(fault_type), .fault_delay(fault_delay), .fault_shift(fault_shift),
    .cfg_load(cfg_load), .out_valid(out_valid), .out_sample(out_sample),
    .line_quiet(line_quiet), .cfg_pending(cfg_pending)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: one expected sample per checked cycle.
  always @(negedge clk) begin : mon
    int e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({phase, ".out"}, int'($signed(out_sample)), e);
      chk({phase, ".ov"}, int'(out_valid), 1);
    end
  end

  // One cycle of stimulus; the expected output for this cycle is queued.
  // in_sample carries junk when invalid to confirm zero is injected instead.
  task automatic step(input logic v, input int smp, input logic ld,
                      input int exp, input bit en);
    in_valid  = v;
    in_sample = v ? DATA_W'(smp) : 12'd77;
    cfg_load  = ld;
    @(posedge clk);
    if (en) sb.push_back(exp);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  // Load while quiet: active two cycles after the load cycle's edge.
  task automatic load_cfg(input logic [2*NF-1:0] t, input logic [DLY_W*NF-1:0] d,
                          input logic [3*NF-1:0] sh);
    fault_type = t; fault_delay = d; fault_shift = sh;
    step(1'b0, 0, 1'b1, 0, 1'b1);
    chk({phase, ".pend_set"}, int'(cfg_pending), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 0, 1'b1);
    chk({phase, ".pend_clr"}, int'(cfg_pending), 0);
  endtask

  // Single pulse followed by n-1 zero cycles; index 0 is the incident output.
  task automatic pulse(input int smp, input int n, input int ia, input int va,
                       input int ib, input int vb);
    step(1'b1, smp, 1'b0, smp, 1'b1);
    for (int i = 1; i < n; i++)
      step(1'b0, 0, 1'b0, (i == ia) ? va : ((i == ib) ? vb : 0), 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; cfg_load = 1'b0;
    fault_type = '0; fault_delay = '0; fault_shift = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset.ov", int'(out_valid), 0);
    chk("reset.out", int'(out_sample), 0);
    chk("reset.quiet", int'(line_quiet), 1);
    chk("reset.pend", int'(cfg_pending), 0);
    rst_n = 1'b1;

    phase = "idle";
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b0, 0, 1'b1);
    chk("idle.quiet", int'(line_quiet), 1);
    chk("idle.pend", int'(cfg_pending), 0);

    phase = "open5";
    load_cfg({2'b00, 2'b01}, {7'd0, 7'd5}, {3'd0, 3'd1});
    pulse(400, 140, 10, 200, -1, 0);

    phase = "short_partial";
    load_cfg({2'b11, 2'b10}, {7'd64, 7'd3}, {3'd0, 3'd0});
    pulse(1000, 140, 6, -1000, 128, 500);

    phase = "sat_pos";
    load_cfg({2'b01, 2'b01}, {7'd4, 7'd4}, {3'd0, 3'd0});
    pulse(2047, 140, 8, 2047, -1, 0);
    phase = "sat_neg";
    pulse(-2048, 140, 8, -2048, -1, 0);

    // Shorts invert a negative pulse: 2048+2048 clips at the positive rail.
    phase = "sat_short";
    load_cfg({2'b10, 2'b10}, {7'd4, 7'd4}, {3'd0, 3'd0});
    pulse(-2048, 140, 8, 2047, -1, 0);

    // Deferred config: the load lands 3 cycles after a pulse.
    phase = "deferred";
    load_cfg({2'b00, 2'b01}, {7'd0, 7'd5}, {3'd0, 3'd1});
    fault_type = {2'b00, 2'b10}; fault_delay = {7'd0, 7'd2}; fault_shift = '0;
    for (int i = 0; i <= 132; i++) begin
      step(i == 0, (i == 0) ? 400 : 0, i == 3,
           (i == 0) ? 400 : ((i == 10) ? 200 : 0), 1'b1);
      if (i == 3)   chk("deferred.pend3", int'(cfg_pending), 1);
      if (i == 127) chk("deferred.quiet127", int'(line_quiet), 0);
      if (i == 127) chk("deferred.pend127", int'(cfg_pending), 1);
      if (i == 128) chk("deferred.quiet128", int'(line_quiet), 1);
      if (i == 129) chk("deferred.pend129", int'(cfg_pending), 1);
      if (i == 130) chk("deferred.pend130", int'(cfg_pending), 0);
    end
    phase = "new_cfg";
    pulse(400, 140, 4, -400, -1, 0);

    // Reset while an echo is in flight and a config is pending.
    phase = "midreset";
    load_cfg({2'b00, 2'b01}, {7'd0, 7'd5}, {3'd0, 3'd1});
    step(1'b1, 400, 1'b0, 400, 1'b1);
    step(1'b0, 0, 1'b0, 0, 1'b1);
    fault_type = {2'b00, 2'b01}; fault_delay = {7'd0, 7'd1}; fault_shift = '0;
    step(1'b0, 0, 1'b1, 0, 1'b1);
    chk("midreset.pend_before", int'(cfg_pending), 1);
    step(1'b0, 0, 1'b0, 0, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 0, 1'b0, 0, 1'b0);
    chk("midreset.ov", int'(out_valid), 0);
    chk("midreset.out", int'(out_sample), 0);
    chk("midreset.quiet", int'(line_quiet), 1);
    chk("midreset.pend", int'(cfg_pending), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b0, 0, 1'b1);
    phase = "after_reset";
    pulse(300, 20, -1, 0, -1, 0);

    @(negedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
